mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mips_mem_pkg.sv | 52 +++++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ============================================================================
// mips_mem_pkg : shared types and lane constants for the memory bus controller
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_FETCH = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam logic [3:0] c_be_none    = 4'b0000;
  localparam logic [3:0] c_be_byte    = 4'b0001;
  localparam logic [3:0] c_be_half_lo = 4'b0011;
  localparam logic [3:0] c_be_half_hi = 4'b1100;
  localparam logic [3:0] c_be_word    = 4'b1111;

  // Instruction fetches are always word sized; the reserved code aliases WORD.
  function automatic logic [1:0] norm_size(input logic [1:0] op, input logic [1:0] size);
    if (op == OP_FETCH || size == SZ_RSVD) return SZ_WORD;
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : byte-lane enables, store data replication, load extraction
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_bus,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_bus[7:0];
    case (addr_lo)
      2'd1:    w_byte = rdata_bus[15:8];
      2'd2:    w_byte = rdata_bus[23:16];
      2'd3:    w_byte = rdata_bus[31:24];
      default: w_byte = rdata_bus[7:0];
    endcase
    w_half = addr_lo[1] ? rdata_bus[31:16] : rdata_bus[15:0];
  end

  always_comb begin
    byteenable = c_be_word;
    writedata  = wdata;
    rdata_ext  = rdata_bus;
    case (size)
      SZ_BYTE: begin
        byteenable = c_be_byte << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign_ext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? c_be_half_hi : c_be_half_lo;
        writedata  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & w_half[15]}}, w_half};
      end
      default: begin
        byteenable = c_be_word;
        writedata  = wdata;
        rdata_ext  = rdata_bus;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// mem_bus_ctrl : single-master memory bus controller for fetch/load/store
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_bus_ctrl
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] instr,
  output logic [31:0] rdata
);

  localparam logic [1:0] c_st_idle   = ST_IDLE;
  localparam logic [1:0] c_st_access = ST_ACCESS;
  localparam logic [1:0] c_st_done   = ST_DONE;
  localparam logic [1:0] c_st_err    = ST_ERR;

  logic [1:0]  r_state;
  logic [1:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_sign_ext;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [3:0]  r_be;
  logic [31:0] r_writedata;
  logic        r_busy;
  logic        r_done;
  logic        r_misal;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;

  logic        w_idle;
  logic [1:0]  w_req_size;
  logic        w_req_misal;
  logic [1:0]  w_al_lo;
  logic [1:0]  w_al_size;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ext;

  assign w_idle      = (r_state == c_st_idle);
  assign w_req_size  = norm_size(op, size);
  assign w_req_misal = is_misaligned(w_req_size, addr[1:0]);

  // The aligner serves the incoming request in IDLE and the latched one in ACCESS.
  assign w_al_lo   = w_idle ? addr[1:0]  : r_addr_lo;
  assign w_al_size = w_idle ? w_req_size : r_size;

  mem_lane_align u_align (
    .addr_lo    (w_al_lo),
    .size       (w_al_size),
    .sign_ext   (r_sign_ext),
    .wdata      (wdata),
    .rdata_bus  (readdata),
    .byteenable (w_be),
    .writedata  (w_wd),
    .rdata_ext  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_op        <= OP_NONE;
      r_addr_lo   <= 2'b00;
      r_size      <= SZ_BYTE;
      r_sign_ext  <= 1'b0;
      r_address   <= 32'h0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_be        <= c_be_none;
      r_writedata <= 32'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_misal     <= 1'b0;
      r_instr     <= 32'h0;
      r_rdata     <= 32'h0;
    end else begin
      r_done  <= 1'b0;
      r_misal <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (op != OP_NONE) begin
            r_op       <= op;
            r_addr_lo  <= addr[1:0];
            r_size     <= w_req_size;
            r_sign_ext <= sign_ext;
            if (w_req_misal) begin
              r_state <= c_st_err;
              r_misal <= 1'b1;
            end else begin
              r_state     <= c_st_access;
              r_busy      <= 1'b1;
              r_address   <= {addr[31:2], 2'b00};
              r_be        <= w_be;
              r_writedata <= w_wd;
              r_read      <= (op != OP_STORE);
              r_write     <= (op == OP_STORE);
            end
          end
        end
        c_st_access: begin
          if (!waitrequest) begin
            r_state <= c_st_done;
            r_busy  <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_done  <= 1'b1;
            if (r_op == OP_FETCH) r_instr <= readdata;
            if (r_op == OP_LOAD)  r_rdata <= w_ext;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_be;
  assign writedata  = r_writedata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign misaligned = r_misal;
  assign instr      = r_instr;
  assign rdata      = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
// ============================================================================
// tb_mem_bus_ctrl : directed bench with a transaction-level reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [1:0]  size = 2'd0;
  logic        sign_ext = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] readdata = 32'h0;
  logic        waitrequest = 1'b0;

  logic [31:0] address, writedata, instr, rdata;
  logic        read, write, busy, done, misaligned;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .addr        (addr),
    .size        (size),
    .sign_ext    (sign_ext),
    .wdata       (wdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .busy        (busy),
    .done        (done),
    .misaligned  (misaligned),
    .instr       (instr),
    .rdata       (rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, outputs derived arithmetically.
  int          m_phase;   // 0 idle, 1 on bus, 2 completion, 3 error
  int          m_bytes, m_off, nb, be_full;
  logic [1:0]  m_op;
  logic        m_sx;
  logic [31:0] mask, v;
  logic [31:0] e_addr, e_wd, m_instr, m_rdata;
  logic [3:0]  e_be;
  logic        e_rd, e_wr, e_busy, e_done, e_mis;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase <= 0;
      e_rd <= 1'b0; e_wr <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0; e_mis <= 1'b0;
      e_addr <= 32'h0; e_be <= 4'h0; e_wd <= 32'h0;
      m_instr <= 32'h0; m_rdata <= 32'h0;
    end else begin
      e_done <= 1'b0;
      e_mis  <= 1'b0;
      case (m_phase)
        0: if (op != 2'd0) begin
          nb = (op == 2'd1) ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
          m_op    <= op;
          m_off   <= int'(addr % 4);
          m_bytes <= nb;
          m_sx    <= sign_ext;
          if (addr % nb != 0) begin
            m_phase <= 3;
            e_mis   <= 1'b1;
          end else begin
            m_phase <= 1;
            e_busy  <= 1'b1;
            e_rd    <= (op != 2'd3);
            e_wr    <= (op == 2'd3);
            e_addr  <= addr & ~32'h3;
            be_full = (1 << nb) - 1;
            e_be    <= 4'(be_full << (addr % 4));
            e_wd    <= (nb == 1) ? (wdata & 32'hff) * 32'h01010101 :
                       (nb == 2) ? (wdata & 32'hffff) * 32'h00010001 : wdata;
          end
        end
        1: if (!waitrequest) begin
          m_phase <= 2;
          e_busy <= 1'b0; e_rd <= 1'b0; e_wr <= 1'b0; e_done <= 1'b1;
          if (m_op == 2'd1) m_instr <= readdata;
          if (m_op == 2'd2) begin
            mask = (m_bytes == 4) ? 32'hffffffff : (32'h1 << (8 * m_bytes)) - 32'h1;
            v = (readdata >> (8 * m_off)) & mask;
            if (m_sx && v[8 * m_bytes - 1]) v = v | ~mask;
            m_rdata <= v;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  int rcnt, wcnt, dcnt, mcnt, bcnt;
  logic [31:0] last_addr, last_wd;
  logic [3:0]  last_be;

  always @(negedge clk) begin
    if (model_on) begin
      chk("read", read, e_rd);
      chk("write", write, e_wr);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("misaligned", misaligned, e_mis);
      chk("instr", instr, m_instr);
      chk("rdata", rdata, m_rdata);
      chk("strobe_excl", read & write, 32'h0);
      if (e_rd || e_wr) begin
        chk("address", address, e_addr);
        chk("byteenable", byteenable, e_be);
        chk("writedata", writedata, e_wd);
      end
      if (read)       rcnt++;
      if (write)      wcnt++;
      if (done)       dcnt++;
      if (misaligned) mcnt++;
      if (busy)       bcnt++;
      if (read || write) begin
        last_addr = address;
        last_be   = byteenable;
        last_wd   = writedata;
      end
    end
  end

  task automatic clr();
    rcnt = 0; wcnt = 0; dcnt = 0; mcnt = 0; bcnt = 0;
  endtask

  task automatic run_req(input logic [1:0] t_op, input logic [31:0] t_addr, input logic [1:0] t_size,
                         input logic t_sx, input logic [31:0] t_wd, input int waits,
                         input logic [31:0] t_rd);
    int j;
    clr();
    @(negedge clk);
    op = t_op; addr = t_addr; size = t_size; sign_ext = t_sx; wdata = t_wd;
    readdata = t_rd; waitrequest = (waits > 0);
    j = 0;
    do begin
      @(negedge clk);
      j++;
      if (j == 1) op = 2'd0;
      waitrequest = (j <= waits);
    end while (!(done || misaligned) && j < 40);
    chk("req_completes", done | misaligned, 32'h1);
    waitrequest = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_on = 1'b1;
    chk("rst_address", address, 32'h0);
    chk("rst_byteenable", byteenable, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", busy, 32'h0);
    reset = 1'b1;

    // Reset while a fetch is stalled: aborted, nothing latched.
    clr();
    @(negedge clk);
    op = 2'd1; addr = 32'h0000_0100; size = 2'd0; waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 2'd0;
    chk("abort_read_before", read, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_read_after", read, 32'h0);
    chk("abort_busy_after", busy, 32'h0);
    chk("abort_instr", instr, 32'h0);
    reset = 1'b1;
    waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", dcnt, 32'h0);

    // Boot fetch.
    run_req(2'd1, 32'hBFC0_0000, 2'd0, 1'b0, 32'h0, 0, 32'h2402_0005);
    chk("fetch_reads", rcnt, 32'h1);
    chk("fetch_addr", last_addr, 32'hBFC0_0000);
    chk("fetch_be", last_be, 32'hF);
    chk("fetch_done", dcnt, 32'h1);
    chk("fetch_instr", instr, 32'h2402_0005);

    // Byte loads from the top lane, signed and unsigned.
    run_req(2'd2, 32'h0000_1003, 2'd0, 1'b1, 32'h0, 0, 32'h80FF_0011);
    chk("lb_be", last_be, 32'h8);
    chk("lb_addr", last_addr, 32'h0000_1000);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    run_req(2'd2, 32'h0000_1003, 2'd0, 1'b0, 32'h0, 0, 32'h80FF_0011);
    chk("lbu_rdata", rdata, 32'h0000_0080);

    // Stalled halfword store.
    run_req(2'd3, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 3, 32'h0);
    chk("sh_write_cycles", wcnt, 32'h4);
    chk("sh_busy_cycles", bcnt, 32'h4);
    chk("sh_be", last_be, 32'hC);
    chk("sh_wd", last_wd, 32'hBEEF_BEEF);
    chk("sh_done", dcnt, 32'h1);

    // Misaligned word load: error pulse, no bus traffic.
    run_req(2'd2, 32'h0000_3001, 2'd2, 1'b0, 32'h0, 0, 32'h1234_5678);
    chk("lw_mis_pulse", mcnt, 32'h1);
    chk("lw_mis_bus", rcnt + wcnt, 32'h0);
    chk("lw_mis_rdata", rdata, 32'h0000_0080);

    run_req(2'd3, 32'h0000_0011, 2'd0, 1'b0, 32'h0000_12AB, 1, 32'h0);
    chk("sb_wd", last_wd, 32'hABAB_ABAB);
    chk("sb_be", last_be, 32'h2);
    run_req(2'd2, 32'h0000_0002, 2'd1, 1'b1, 32'h0, 2, 32'h8001_1234);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    run_req(2'd2, 32'h0000_0001, 2'd1, 1'b0, 32'h0, 0, 32'h0);
    chk("lh_mis_pulse", mcnt, 32'h1);
    run_req(2'd1, 32'h0000_0002, 2'd0, 1'b0, 32'h0, 0, 32'hFFFF_FFFF);
    chk("fetch_mis_instr", instr, 32'h2402_0005);
    run_req(2'd2, 32'h0000_0008, 2'd3, 1'b1, 32'h0, 0, 32'h1122_3344);
    chk("lw_rsvd_rdata", rdata, 32'h1122_3344);
    run_req(2'd2, 32'h0000_0001, 2'd0, 1'b1, 32'h0, 0, 32'h0000_7F00);
    chk("lb_pos_rdata", rdata, 32'h0000_007F);
    run_req(2'd3, 32'h0000_0040, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 32'h0);
    chk("sw_wd", last_wd, 32'hCAFE_F00D);

    // Held request: accepted again after one idle cycle.
    clr();
    @(negedge clk);
    op = 2'd2; addr = 32'h0; size = 2'd0; sign_ext = 1'b1; readdata = 32'h0000_00FF;
    repeat (3) @(negedge clk);
    @(negedge clk);
    op = 2'd0;
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_done", dcnt, 32'h2);
    chk("b2b_reads", rcnt, 32'h2);
    chk("b2b_rdata", rdata, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
